// File: rtl/spad_scan_ctrl_if.sv
// spad_scan_ctrl_if
// Bundles the SPAD chip pins and the readout FIFO write port that the scan
// sequencer drives.
//   ADDRESS    pixel address presented to the chip
//   MEM_CLEAR  chip counter clear strobe
//   SPAD_ON    SPAD exposure enable
//   READ       chip readout strobe
//   DIN        per-frame SPAD count returned by the chip
//   fifo_full  FIFO cannot accept a write this cycle
//   fifo_wr    one-cycle FIFO write strobe
//   fifo_dout  tagged result word {pixel address, accumulated count}
// master: the sequencer side; slave: the chip / FIFO side.
interface spad_scan_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 5
);
  logic [ADDR_W-1:0] ADDRESS;
  logic              MEM_CLEAR;
  logic              SPAD_ON;
  logic              READ;
  logic [CNT_W-1:0]  DIN;
  logic              fifo_full;
  logic              fifo_wr;
  logic [31:0]       fifo_dout;

  modport master (
    output ADDRESS, MEM_CLEAR, SPAD_ON, READ, fifo_wr, fifo_dout,
    input  DIN, fifo_full
  );

  modport slave (
    input  ADDRESS, MEM_CLEAR, SPAD_ON, READ, fifo_wr, fifo_dout,
    output DIN, fifo_full
  );
endinterface

// File: rtl/spad_scan_ctrl.sv
// spad_scan_ctrl
// Scan sequencer for the SPAD chip interface. For every pixel address in the
// range start_addr..stop_addr (wrapping through the top of the address space
// when start_addr > stop_addr) it runs F clear/expose/read frames, sums the
// per-frame counts into a saturating accumulator and pushes one tagged word
// per pixel into the readout FIFO.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            scan enable; dropping it aborts a scan in progress
//   start         one-cycle pulse, accepted only when idle and enabled
//   start_addr    first pixel address, latched on start
//   stop_addr     last pixel address (inclusive), latched on start
//   integ_cycles  exposure length in clk cycles (0 behaves as 1)
//   n_frames      frames accumulated per pixel (0 behaves as 1)
//   bus           chip pins and FIFO write port (master modport)
//   busy          scan in progress
//   done          one-cycle pulse after the last pixel word is written
//   sat           sticky saturation flag for the current scan
module spad_scan_ctrl #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 5,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic [15:0]       integ_cycles,
  input  logic [7:0]        n_frames,
  spad_scan_ctrl_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, EXPOSE, RDSET, SAMPLE, WRITE, NEXT
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [15:0]       t_cfg;
  logic [15:0]       tmr;
  logic [7:0]        f_cfg;
  logic [7:0]        frame;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_next;
  logic              clamp;
  logic              last_frame;

  // One extra bit on the sum catches overflow; the accumulator then pins at
  // its maximum rather than wrapping.
  always_comb begin
    acc_sum  = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, bus.DIN};
    clamp    = acc_sum[ACC_W];
    acc_next = clamp ? ACC_MAX : acc_sum[ACC_W-1:0];
  end

  // frame counts completed frames before this SAMPLE, so this is the last
  // one when frame+1 reaches F.
  assign last_frame = ({1'b0, frame} + 9'd1) >= {1'b0, f_cfg};

  // All outputs are registered: each transition also loads the output values
  // for the state being entered, so strobes line up with the state cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      last_addr     <= '0;
      t_cfg         <= 16'd1;
      tmr           <= '0;
      f_cfg         <= 8'd1;
      frame         <= '0;
      acc           <= '0;
      bus.ADDRESS   <= '0;
      bus.MEM_CLEAR <= 1'b0;
      bus.SPAD_ON   <= 1'b0;
      bus.READ      <= 1'b0;
      bus.fifo_wr   <= 1'b0;
      bus.fifo_dout <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sat           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && !en) begin
        // Abort: drop every strobe at once; any word not yet strobed is lost.
        state         <= IDLE;
        bus.MEM_CLEAR <= 1'b0;
        bus.SPAD_ON   <= 1'b0;
        bus.READ      <= 1'b0;
        bus.fifo_wr   <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && en) begin
              cur_addr      <= start_addr;
              last_addr     <= stop_addr;
              t_cfg         <= (integ_cycles == 16'd0) ? 16'd1 : integ_cycles;
              f_cfg         <= (n_frames == 8'd0) ? 8'd1 : n_frames;
              acc           <= '0;
              frame         <= '0;
              sat           <= 1'b0;
              busy          <= 1'b1;
              bus.ADDRESS   <= start_addr;
              bus.MEM_CLEAR <= 1'b1;
              state         <= CLEAR;
            end
          end
          CLEAR: begin
            bus.MEM_CLEAR <= 1'b0;
            bus.SPAD_ON   <= 1'b1;
            tmr           <= t_cfg;
            state         <= EXPOSE;
          end
          EXPOSE: begin
            if (tmr == 16'd1) begin
              bus.SPAD_ON <= 1'b0;
              bus.READ    <= 1'b1;
              state       <= RDSET;
            end else begin
              tmr <= tmr - 16'd1;
            end
          end
          RDSET: begin
            state <= SAMPLE;
          end
          SAMPLE: begin
            bus.READ <= 1'b0;
            acc      <= acc_next;
            frame    <= frame + 8'd1;
            if (clamp) begin
              sat <= 1'b1;
            end
            if (last_frame) begin
              // Word is built from the freshly updated sum and held for the
              // whole of WRITE, including any backpressure stall.
              bus.fifo_dout <= 32'({cur_addr, acc_next});
              bus.fifo_wr   <= !bus.fifo_full;
              state         <= WRITE;
            end else begin
              bus.MEM_CLEAR <= 1'b1;
              state         <= CLEAR;
            end
          end
          WRITE: begin
            if (bus.fifo_wr) begin
              bus.fifo_wr <= 1'b0;
              state       <= NEXT;
            end else if (!bus.fifo_full) begin
              bus.fifo_wr <= 1'b1;
            end
          end
          NEXT: begin
            if (cur_addr == last_addr) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cur_addr      <= cur_addr + ADDR_W'(1);
              bus.ADDRESS   <= cur_addr + ADDR_W'(1);
              acc           <= '0;
              frame         <= '0;
              bus.MEM_CLEAR <= 1'b1;
              state         <= CLEAR;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
